// File: rtl/idp_sequencer_if.sv
// Request/ack bus shared by the two requesters and the datapath control word
// driven back by the sequencer.
interface idp_sequencer_if;
  logic        req_a, req_b;
  logic [2:0]  cls_a, cls_b;
  logic [4:0]  fs_a, fs_b, s_a, s_b, t_a, t_b, d_a, d_b;
  logic [31:0] imm_a, imm_b;
  logic        ack_a, ack_b, err, busy;
  logic        D_En, HILO_ld, VHILO_ld, S_Sel;
  logic [1:0]  D_sel, T_Sel;
  logic [2:0]  Y_Sel;
  logic [4:0]  D_Addr, S_Addr, T_Addr, FS;
  logic [31:0] DT;

  modport master (
    output req_a, req_b, cls_a, cls_b, fs_a, fs_b, s_a, s_b, t_a, t_b, d_a, d_b, imm_a, imm_b,
    input  ack_a, ack_b, err, busy, D_En, HILO_ld, VHILO_ld, S_Sel,
           D_sel, T_Sel, Y_Sel, D_Addr, S_Addr, T_Addr, FS, DT
  );

  modport slave (
    input  req_a, req_b, cls_a, cls_b, fs_a, fs_b, s_a, s_b, t_a, t_b, d_a, d_b, imm_a, imm_b,
    output ack_a, ack_b, err, busy, D_En, HILO_ld, VHILO_ld, S_Sel,
           D_sel, T_Sel, Y_Sel, D_Addr, S_Addr, T_Addr, FS, DT
  );
endinterface

// File: rtl/idp_sequencer.sv
// Integer datapath sequencer: arbitrates between two requesters, latches the
// winning operation and walks the datapath through READ, EXEC and WB.
// All datapath controls are Moore outputs decoded from state and latched fields.
module idp_sequencer #(
  parameter bit FAIR             = 1'b1,
  parameter bit ZERO_WB_SUPPRESS = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  idp_sequencer_if.slave io_bus
);

  localparam logic [2:0] CLS_RR     = 3'b000;
  localparam logic [2:0] CLS_RI     = 3'b001;
  localparam logic [2:0] CLS_MULDIV = 3'b010;
  localparam logic [2:0] CLS_MFHI   = 3'b011;
  localparam logic [2:0] CLS_MFLO   = 3'b100;
  localparam logic [2:0] CLS_VALU   = 3'b101;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  state_t      r_state, w_next;
  logic        r_grantB, r_ptrB;
  logic [2:0]  r_cls;
  logic [4:0]  r_fs, r_s, r_t, r_d;
  logic [31:0] r_imm;
  logic        w_grant, w_pickB, w_done;
  logic [2:0]  w_pickCls;
  logic [4:0]  w_effDest;

  // Arbitration: round-robin pointer breaks ties when FAIR, else A has priority
  always_comb begin
    w_grant = io_bus.req_a | io_bus.req_b;
    if (FAIR) begin
      w_pickB = io_bus.req_b & (~io_bus.req_a | r_ptrB);
    end else begin
      w_pickB = io_bus.req_b & ~io_bus.req_a;
    end
    w_pickCls = w_pickB ? io_bus.cls_b : io_bus.cls_a;
  end

  // RI writes back through the T address, every other class through D
  assign w_effDest = (r_cls == CLS_RI) ? r_t : r_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the winner's fields and move the fairness pointer only on a grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grantB <= 1'b0;
      r_ptrB   <= 1'b0;
      r_cls    <= 3'd0;
      r_fs     <= 5'd0;
      r_s      <= 5'd0;
      r_t      <= 5'd0;
      r_d      <= 5'd0;
      r_imm    <= 32'd0;
    end else if (r_state == IDLE && w_grant) begin
      r_grantB <= w_pickB;
      r_ptrB   <= ~w_pickB;
      r_cls    <= w_pickCls;
      r_fs     <= w_pickB ? io_bus.fs_b  : io_bus.fs_a;
      r_s      <= w_pickB ? io_bus.s_b   : io_bus.s_a;
      r_t      <= w_pickB ? io_bus.t_b   : io_bus.t_a;
      r_d      <= w_pickB ? io_bus.d_b   : io_bus.d_a;
      r_imm    <= w_pickB ? io_bus.imm_b : io_bus.imm_a;
    end
  end

  // Next-state: move-from-HI/LO skip straight to writeback, MULDIV ends in EXEC
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          case (w_pickCls)
            CLS_RR, CLS_RI, CLS_MULDIV, CLS_VALU: w_next = READ;
            CLS_MFHI, CLS_MFLO:                   w_next = WB;
            default:                              w_next = ERR;
          endcase
        end
      end
      READ:    w_next = EXEC;
      EXEC:    w_next = (r_cls == CLS_MULDIV) ? IDLE : WB;
      WB:      w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore control word; addresses and FS stay stable from READ through WB
  always_comb begin
    io_bus.D_En     = 1'b0;
    io_bus.HILO_ld  = 1'b0;
    io_bus.VHILO_ld = 1'b0;
    io_bus.S_Sel    = 1'b0;
    io_bus.D_sel    = 2'b00;
    io_bus.T_Sel    = 2'b00;
    io_bus.Y_Sel    = 3'd0;
    io_bus.D_Addr   = 5'd0;
    io_bus.S_Addr   = 5'd0;
    io_bus.T_Addr   = 5'd0;
    io_bus.FS       = 5'd0;
    io_bus.DT       = 32'd0;
    io_bus.err      = 1'b0;
    io_bus.busy     = (r_state != IDLE);
    w_done          = 1'b0;
    if (r_state == READ || r_state == EXEC || r_state == WB) begin
      io_bus.S_Addr = r_s;
      io_bus.T_Addr = r_t;
      io_bus.D_Addr = r_d;
      io_bus.FS     = r_fs;
      if (r_cls == CLS_RI) begin
        io_bus.T_Sel = 2'b01;
        io_bus.DT    = r_imm;
      end
    end
    case (r_state)
      EXEC: begin
        io_bus.HILO_ld  = (r_cls == CLS_MULDIV);
        io_bus.VHILO_ld = (r_cls == CLS_VALU);
        w_done          = (r_cls == CLS_MULDIV);
      end
      WB: begin
        io_bus.D_En  = !(ZERO_WB_SUPPRESS && w_effDest == 5'd0);
        io_bus.D_sel = (r_cls == CLS_RI) ? 2'b01 : 2'b00;
        case (r_cls)
          CLS_MFHI: io_bus.Y_Sel = 3'd0;
          CLS_MFLO: io_bus.Y_Sel = 3'd1;
          CLS_VALU: io_bus.Y_Sel = 3'd7;
          default:  io_bus.Y_Sel = 3'd2;
        endcase
        w_done = 1'b1;
      end
      ERR: begin
        io_bus.err = 1'b1;
        w_done     = 1'b1;
      end
      default: ;
    endcase
    io_bus.ack_a = w_done & ~r_grantB;
    io_bus.ack_b = w_done & r_grantB;
  end

endmodule

// File: tb/tb_idp_sequencer.sv
// Testbench for idp_sequencer: a small register-file datapath driven by the
// control word, an ISA-level reference model, directed and random operations.
module tb_idp_sequencer;

  localparam logic [2:0] RR = 3'd0, RI = 3'd1, MD = 3'd2, MFHI = 3'd3, MFLO = 3'd4, VALU = 3'd5;

  logic clk = 1'b0;
  logic reset;
  logic dpInit;
  logic reqA, reqB;
  logic [2:0] clsA, clsB;
  logic [4:0] fsA, fsB, sA, sB, tA, tB, dA, dB;
  logic [31:0] immA, immB;

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  idp_sequencer_if bus ();
  idp_sequencer_if bus0 ();

  assign bus.req_a = reqA;  assign bus0.req_a = reqA;
  assign bus.req_b = reqB;  assign bus0.req_b = reqB;
  assign bus.cls_a = clsA;  assign bus0.cls_a = clsA;
  assign bus.cls_b = clsB;  assign bus0.cls_b = clsB;
  assign bus.fs_a  = fsA;   assign bus0.fs_a  = fsA;
  assign bus.fs_b  = fsB;   assign bus0.fs_b  = fsB;
  assign bus.s_a   = sA;    assign bus0.s_a   = sA;
  assign bus.s_b   = sB;    assign bus0.s_b   = sB;
  assign bus.t_a   = tA;    assign bus0.t_a   = tA;
  assign bus.t_b   = tB;    assign bus0.t_b   = tB;
  assign bus.d_a   = dA;    assign bus0.d_a   = dA;
  assign bus.d_b   = dB;    assign bus0.d_b   = dB;
  assign bus.imm_a = immA;  assign bus0.imm_a = immA;
  assign bus.imm_b = immB;  assign bus0.imm_b = immB;

  idp_sequencer #(.FAIR(1'b1), .ZERO_WB_SUPPRESS(1'b1)) dut (
    .clk(clk), .reset(reset), .io_bus(bus.slave)
  );

  idp_sequencer #(.FAIR(1'b0), .ZERO_WB_SUPPRESS(1'b1)) dut0 (
    .clk(clk), .reset(reset), .io_bus(bus0.slave)
  );

  // ISA-level ALU: FS 0 add, 1 sub, 2 and, 3 or, 4 xor
  function automatic logic [31:0] alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] initVal(input int i);
    case (i)
      0:       return 32'd0;
      1:       return 32'h20;
      2:       return 32'd5;
      3:       return 32'd7;
      default: return 32'(i) * 32'h0101_0101 + 32'h1234;
    endcase
  endfunction

  // Datapath environment controlled by the main sequencer
  logic [31:0] regs [32];
  logic [31:0] rs, rt, aluOut, hi, lo, vlo, yMux;
  wire  [31:0] tMux  = (bus.T_Sel == 2'b01) ? bus.DT : rt;
  wire  [4:0]  wAddr = (bus.D_sel == 2'b01) ? bus.T_Addr : bus.D_Addr;

  always_comb begin
    case (bus.Y_Sel)
      3'd0:    yMux = hi;
      3'd1:    yMux = lo;
      3'd2:    yMux = aluOut;
      3'd7:    yMux = vlo;
      default: yMux = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (dpInit) begin
      for (int i = 0; i < 32; i++) regs[i] <= initVal(i);
      rs <= 32'd0; rt <= 32'd0; aluOut <= 32'd0; hi <= 32'd0; lo <= 32'd0; vlo <= 32'd0;
    end else begin
      rs     <= regs[bus.S_Addr];
      rt     <= regs[bus.T_Addr];
      aluOut <= alu(bus.FS, rs, tMux);
      if (bus.HILO_ld) {hi, lo} <= {32'd0, rs} * {32'd0, tMux};
      if (bus.VHILO_ld) vlo <= ~alu(bus.FS, rs, tMux);
      if (bus.D_En && wAddr != 5'd0) regs[wAddr] <= yMux;
    end
  end

  // Reference architectural state
  logic [31:0] mRegs [32];
  logic [31:0] mHi, mLo;

  function automatic logic [63:0] ctlWord();
    return {29'd0, bus.ack_a, bus.ack_b, bus.err, bus.busy, bus.D_En, bus.HILO_ld, bus.VHILO_ld,
            bus.S_Sel, bus.D_sel, bus.T_Sel, bus.Y_Sel, bus.D_Addr, bus.S_Addr, bus.T_Addr, bus.FS};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from an idle cycle and check it against the model
  task automatic applyStimulus(input bit portB, input logic [2:0] cls, input logic [4:0] fs,
                               input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                               input logic [31:0] imm, input bit dropEarly);
    int expLat, ackCyc, nHilo, nVhilo, nDen;
    bit readCls, writes, expDen, ownAck, otherAck;
    logic [4:0] dest;
    logic [31:0] val;
    logic [2:0] expY;
    logic [63:0] prod;
    string tag;
    tag = $sformatf("%s cls%0d", portB ? "B" : "A", cls);
    readCls = cls inside {RR, RI, MD, VALU};
    writes  = cls inside {RR, RI, VALU, MFHI, MFLO};
    case (cls)
      RR, RI, VALU: expLat = 3;
      MD:           expLat = 2;
      default:      expLat = 1;
    endcase
    dest = (cls == RI) ? t : d;
    case (cls)
      RR:      val = alu(fs, mRegs[s], mRegs[t]);
      RI:      val = alu(fs, mRegs[s], imm);
      VALU:    val = ~alu(fs, mRegs[s], mRegs[t]);
      MFHI:    val = mHi;
      MFLO:    val = mLo;
      default: val = 32'd0;
    endcase
    case (cls)
      MFHI:    expY = 3'd0;
      MFLO:    expY = 3'd1;
      VALU:    expY = 3'd7;
      default: expY = 3'd2;
    endcase
    expDen = writes && (dest != 5'd0);
    prod = {32'd0, mRegs[s]} * {32'd0, mRegs[t]};
    if (portB) begin
      reqB = 1'b1; clsB = cls; fsB = fs; sB = s; tB = t; dB = d; immB = imm;
    end else begin
      reqA = 1'b1; clsA = cls; fsA = fs; sA = s; tA = t; dA = d; immA = imm;
    end
    ackCyc = 0; nHilo = 0; nVhilo = 0; nDen = 0;
    for (int cyc = 1; cyc <= 8 && ackCyc == 0; cyc++) begin
      tick();
      if (dropEarly && cyc == 1) begin
        reqA = 1'b0; reqB = 1'b0;
      end
      if (portB) begin
        clsA = 3'($urandom); dA = 5'($urandom); immA = $urandom;
      end else begin
        clsB = 3'($urandom); dB = 5'($urandom); immB = $urandom;
      end
      ownAck   = portB ? bus.ack_b : bus.ack_a;
      otherAck = portB ? bus.ack_a : bus.ack_b;
      nHilo  += int'(bus.HILO_ld);
      nVhilo += int'(bus.VHILO_ld);
      nDen   += int'(bus.D_En);
      checkOutput({tag, " other ack"}, otherAck, 0);
      checkOutput({tag, " hilo/vhilo overlap"}, bus.HILO_ld & bus.VHILO_ld, 0);
      if (readCls && cyc == 1) begin
        checkOutput({tag, " READ S_Addr"}, bus.S_Addr, s);
        checkOutput({tag, " READ T_Addr"}, bus.T_Addr, t);
        checkOutput({tag, " READ T_Sel"}, bus.T_Sel, (cls == RI) ? 2'b01 : 2'b00);
        if (cls == RI) checkOutput({tag, " READ DT"}, bus.DT, imm);
      end
      if (readCls && cyc == 2) checkOutput({tag, " EXEC FS"}, bus.FS, fs);
      if (ownAck) begin
        ackCyc = cyc;
        reqA = 1'b0; reqB = 1'b0;
        checkOutput({tag, " err"}, bus.err, (cls > VALU) ? 1 : 0);
        if (cls == MD) checkOutput({tag, " HILO_ld with ack"}, bus.HILO_ld, 1);
        if (writes) begin
          checkOutput({tag, " WB D_En"}, bus.D_En, expDen);
          checkOutput({tag, " WB D_Addr"}, bus.D_Addr, d);
          checkOutput({tag, " WB Y_Sel"}, bus.Y_Sel, expY);
          checkOutput({tag, " WB D_sel"}, bus.D_sel, (cls == RI) ? 2'b01 : 2'b00);
        end
        if (readCls) begin
          checkOutput({tag, " stable FS"}, bus.FS, fs);
          checkOutput({tag, " stable S_Addr"}, bus.S_Addr, s);
        end
      end
    end
    reqA = 1'b0; reqB = 1'b0;
    checkOutput({tag, " ack latency"}, ackCyc, expLat);
    checkOutput({tag, " HILO_ld count"}, nHilo, (cls == MD) ? 1 : 0);
    checkOutput({tag, " VHILO_ld count"}, nVhilo, (cls == VALU) ? 1 : 0);
    checkOutput({tag, " D_En count"}, nDen, expDen ? 1 : 0);
    tick();
    checkOutput({tag, " idle after ack"}, bus.busy, 0);
    if (cls == MD) begin
      mHi = prod[63:32];
      mLo = prod[31:0];
    end
    if (writes && dest != 5'd0) mRegs[dest] = val;
    if (writes) checkOutput({tag, " reg result"}, regs[dest], mRegs[dest]);
  endtask

  initial begin
    bit [2:0] orderFair, orderFix;
    int nFair, nFix;
    reqA = 0; reqB = 0; clsA = 0; clsB = 0; fsA = 0; fsB = 0; sA = 0; sB = 0;
    tA = 0; tB = 0; dA = 0; dB = 0; immA = 0; immB = 0;
    reset = 1'b1; dpInit = 1'b1;
    for (int i = 0; i < 32; i++) mRegs[i] = initVal(i);
    mHi = 32'd0; mLo = 32'd0;
    tick(); tick();
    $display("[TB] reset state");
    checkOutput("reset ctl", ctlWord(), 0);
    checkOutput("reset DT", bus.DT, 0);
    reset = 1'b0; dpInit = 1'b0;
    tick();
    checkOutput("idle busy", bus.busy, 0);

    $display("[TB] directed operations");
    applyStimulus(1'b0, RR, 5'd0, 5'd2, 5'd3, 5'd4, 32'd0, 1'b0);
    checkOutput("R4 = R2+R3", regs[4], 32'd12);
    applyStimulus(1'b1, RI, 5'd0, 5'd1, 5'd9, 5'd7, 32'h10, 1'b0);
    checkOutput("R9 = R1+imm", regs[9], 32'h30);
    applyStimulus(1'b0, MD, 5'd0, 5'd2, 5'd3, 5'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, MFLO, 5'd0, 5'd0, 5'd0, 5'd10, 32'd0, 1'b0);
    checkOutput("R10 = LO", regs[10], 32'd35);
    applyStimulus(1'b1, MFHI, 5'd0, 5'd0, 5'd0, 5'd11, 32'd0, 1'b0);
    applyStimulus(1'b1, 3'b111, 5'd0, 5'd1, 5'd2, 5'd5, 32'd0, 1'b0);
    applyStimulus(1'b0, RR, 5'd0, 5'd2, 5'd3, 5'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, VALU, 5'd1, 5'd2, 5'd3, 5'd12, 32'd0, 1'b0);
    checkOutput("R12 = VALU", regs[12], 32'd1);
    applyStimulus(1'b1, RR, 5'd4, 5'd9, 5'd4, 5'd13, 32'd0, 1'b1);

    $display("[TB] contention");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reqA = 1; reqB = 1; clsA = RR; clsB = RR; fsA = 0; fsB = 0;
    sA = 1; sB = 1; tA = 2; tB = 2; dA = 0; dB = 0;
    orderFair = 0; orderFix = 0; nFair = 0; nFix = 0;
    for (int cyc = 0; cyc < 30 && (nFair < 3 || nFix < 3); cyc++) begin
      tick();
      if (bus.ack_a | bus.ack_b) begin
        if (nFair < 3) orderFair[nFair] = bus.ack_b;
        nFair++;
      end
      if (bus0.ack_a | bus0.ack_b) begin
        if (nFix < 3) orderFix[nFix] = bus0.ack_b;
        nFix++;
      end
      if (nFair >= 3 && nFix >= 3) begin
        reqA = 0; reqB = 0;
      end
    end
    reqA = 0; reqB = 0;
    checkOutput("fair grant count", nFair, 3);
    checkOutput("fixed grant count", nFix, 3);
    checkOutput("fair order A,B,A", orderFair, 3'b010);
    checkOutput("fixed order A,A,A", orderFix, 3'b000);
    for (int cyc = 0; cyc < 8 && (bus.busy || bus0.busy); cyc++) tick();
    tick();

    $display("[TB] reset during EXEC");
    reqA = 1; clsA = RR; fsA = 0; sA = 2; tA = 3; dA = 6;
    tick();
    tick();
    checkOutput("busy in EXEC", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort ctl", ctlWord(), 0);
    checkOutput("abort DT", bus.DT, 0);
    reqA = 0;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("abort R6 unchanged", regs[6], mRegs[6]);
    applyStimulus(1'b0, RR, 5'd0, 5'd2, 5'd3, 5'd6, 32'd0, 1'b0);
    checkOutput("R6 after abort", regs[6], 32'd12);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 4)),
                    5'($urandom), 5'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/idp_sequencer.md
Name: idp_sequencer

Overview:
- Multi-cycle controller that owns the integer datapath's control word: register-file addresses, FS, T/S/D/Y selects, D_En, HILO_ld and VHILO_ld.
- Two requesters share it: port A (CPU control unit) and port B (debug/test port). It arbitrates between them, latches the winning operation, then steps the datapath through READ, EXEC and WB.
- Requesters see a req/ack handshake and never drive datapath controls directly.

Parameters:
- FAIR, 1: 1 = round-robin between A and B; 0 = fixed priority, A always wins.
- ZERO_WB_SUPPRESS, 1: 1 = suppress D_En whenever the effective destination register is 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_a, req_b  in  1  operation request; held high until the matching ack
- cls_a, cls_b  in  3  operation class (encoding below)
- fs_a, fs_b  in  5  ALU/VALU function select
- s_a, s_b, t_a, t_b, d_a, d_b  in  5  source S, source T and destination register addresses
- imm_a, imm_b  in  32  immediate for class RI
- ack_a, ack_b  out  1  one-cycle completion pulse
- err  out  1  qualifies ack: illegal class
- busy  out  1  high when state is not IDLE
- D_En, HILO_ld, VHILO_ld, S_Sel  out  1  datapath controls
- D_sel, T_Sel  out  2  datapath controls
- Y_Sel  out  3  datapath controls
- D_Addr, S_Addr, T_Addr, FS  out  5  datapath controls
- DT  out  32  immediate driven to the T-mux

Behaviour:
- Class encoding: 000 RR, 001 RI, 010 MULDIV, 011 MFHI, 100 MFLO, 101 VALU, 110/111 illegal.
- States: IDLE, READ, EXEC, WB, ERR. All outputs are Moore, decoded from state and latched fields.
- Reset (asynchronous):
  - State goes to IDLE; every output is 0; latched fields are cleared.
  - The round-robin pointer is set so that A wins the first contention.
  - Reset mid-operation aborts it: no ack, no write.
- IDLE arbitration:
  - Samples req_a and req_b. The winner's cls/fs/s/t/d/imm fields are latched at that edge.
  - FAIR=1: when both are requesting, the port not granted last wins. The pointer updates only on grant.
  - FAIR=0: A wins whenever req_a is high.
- Next state from IDLE:
  - RR, RI, MULDIV, VALU: go to READ.
  - MFHI, MFLO: go to WB.
  - Illegal class: go to ERR.
- READ:
  - S_Addr and T_Addr are driven from the latched fields.
  - RI: T_Sel=01 and DT=imm. All other classes: T_Sel=00.
  - S_Sel=0.
  - RS/RT latch at the end of the cycle. Next state is EXEC.
- EXEC:
  - FS is driven.
  - MULDIV: HILO_ld=1, ack in this cycle, then IDLE.
  - VALU: VHILO_ld=1, then WB.
  - RR, RI: go to WB. The ALU_OUT register captures Y_LO at the end of the cycle.
- WB:
  - D_En=1 and ack is pulsed.
  - RR: D_sel=00, D_Addr=d, Y_Sel=2.
  - RI: D_sel=01 (writes to T_Addr), Y_Sel=2.
  - MFHI: D_sel=00, Y_Sel=0. MFLO: D_sel=00, Y_Sel=1.
  - VALU: D_sel=00, Y_Sel=7.
  - ZERO_WB_SUPPRESS=1 and effective destination is 0: D_En=0, ack still pulsed.
  - Next state is IDLE.
- ERR: ack for the granted port with err=1, no datapath strobes, then IDLE.
- Stability: FS, S_Addr, T_Addr, T_Sel, DT and D_Addr hold the latched values from READ through WB. The ALU_OUT register reloads every cycle, so FS must not change between EXEC and WB.
- Strobes: HILO_ld and VHILO_ld are never asserted in the same cycle. HILO_ld, VHILO_ld and D_En are each high for at most one cycle per operation.
- Latency, counted from the IDLE sampling cycle (cycle 0):
  - RR, RI, VALU: ack in cycle 3.
  - MULDIV: ack in cycle 2.
  - MFHI, MFLO: ack in cycle 1.
  - Illegal: ack+err in cycle 1.
- Handshake:
  - The requester drops req in the cycle after ack.
  - After every ack there is one IDLE cycle, which arbitrates again. RR throughput is therefore 1 operation per 4 cycles.
  - The losing request stays pending with no ack.
  - Changes on the non-granted port while busy are ignored.
- Simultaneous events:
  - req dropped before ack: the operation still completes and ack is still pulsed.
  - Both requests arriving in the same IDLE cycle: resolved by the arbitration rule above.

Test Plan:
- Reset then RR on A (cls=000, s=2, t=3, d=4, fs=ADD; R2=5, R3=7):
  - cycle 1: S_Addr=2, T_Addr=3.
  - cycle 2: FS=ADD.
  - cycle 3: D_En=1, D_Addr=4, Y_Sel=2, ack_a=1.
  - R4=12.
- RI on B (t=9, s=1, imm=0x10, R1=0x20):
  - READ: T_Sel=01, DT=0x10.
  - WB: D_sel=01, ack_b in cycle 3.
  - R9=0x30.
- MULDIV then MFLO on A:
  - MULDIV: HILO_ld high exactly once, in cycle 2, together with ack_a; no D_En.
  - MFLO: WB one cycle after its grant with Y_Sel=1 and D_En=1; destination gets LO.
- Contention:
  - FAIR=1, req_a and req_b both held for 3 operations: grant order A, B, A.
  - FAIR=0, same stimulus: grant order A, A, A.
- Edge cases:
  - cls=111 on B: ack_b with err=1 in cycle 1, no strobes.
  - RR with d=0: ack_a pulses, D_En stays 0.
- Reset asserted during EXEC of RR: all outputs 0 immediately, no ack, R[d] unchanged; the next request completes normally.
